mem_port_arbiter: RTL and testbench

- Shares the single-port 64K x 16 main memory between two requesters of the stack processor: the instruction-fetch unit (F port) and the load/store unit (D port).
- Serializes accesses and tracks one outstanding transaction at a time.
- Routes read data back to the owner.
- Prevents fetch starvation under sustained load/store traffic.
- Sits between the processor core and the memory macro.

---
 rtl/sik_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sik_pkg.sv
// Shared constants and encodings for the stack-processor memory subsystem.
package sik_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    // Arbiter sequencing: nothing outstanding, or one access in flight.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Which requester owns the access currently in flight.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

endpackage : sik_pkg

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port main memory between the fetch (F) and
// load/store (D) units. One access is outstanding at a time; the issue slot
// reopens on the completion cycle so back-to-back accesses run at one per
// MEM_LAT cycles. D has priority, but F is forced through after STARVE_MAX
// consecutive D grants taken while F was waiting.
module mem_port_arbiter #(
    parameter int WORD_W     = sik_pkg::WORD_W,
    parameter int ADDR_W     = sik_pkg::ADDR_W,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [WORD_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [WORD_W-1:0] m_wdata,
    input  logic [WORD_W-1:0] m_rdata
);

    import sik_pkg::*;

    // Latency counter holds 1..4; starvation counter saturates at STARVE_MAX.
    localparam int LAT_W = 3;
    localparam int SC_W  = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_MAX);

    state_e            state_r;
    state_e            state_nxt_s;
    owner_e            owner_r;
    owner_e            owner_nxt_s;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic [LAT_W-1:0]  lat_nxt_s;
    logic [SC_W-1:0]   starve_cnt_r;
    logic [SC_W-1:0]   starve_nxt_s;
    logic              store_r;
    logic              store_nxt_s;

    logic              complete_s;
    logic              slot_open_s;
    logic              win_d_s;
    logic              win_f_s;

    // Final cycle of the in-flight access: rvalid fires and a new issue may overlap.
    always_comb begin
        complete_s = 1'b0;
        if ((state_r == ST_WAIT) && (lat_cnt_r == 3'd1)) begin
            complete_s = 1'b1;
        end else begin
            complete_s = 1'b0;
        end
    end

    // Open the issue slot and pick the winner: D first unless F has waited out STARVE_MAX D grants.
    always_comb begin
        slot_open_s = 1'b0;
        win_d_s     = 1'b0;
        win_f_s     = 1'b0;
        if (reset && !halt && ((state_r == ST_IDLE) || complete_s)) begin
            slot_open_s = 1'b1;
        end else begin
            slot_open_s = 1'b0;
        end
        if (slot_open_s && d_req && !(f_req && (starve_cnt_r == SC_MAX))) begin
            win_d_s = 1'b1;
        end else if (slot_open_s && f_req) begin
            win_f_s = 1'b1;
        end else begin
            win_d_s = 1'b0;
            win_f_s = 1'b0;
        end
    end

    // State register: async reset drops any in-flight access so no rvalid follows release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_NONE;
            lat_cnt_r    <= {LAT_W{1'b0}};
            starve_cnt_r <= {SC_W{1'b0}};
            store_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            lat_cnt_r    <= lat_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            store_r      <= store_nxt_s;
        end
    end

    // Next state: issue reloads the latency count, otherwise count down and retire to IDLE.
    always_comb begin
        state_nxt_s  = state_r;
        owner_nxt_s  = owner_r;
        lat_nxt_s    = lat_cnt_r;
        store_nxt_s  = store_r;
        starve_nxt_s = starve_cnt_r;
        if (win_d_s || win_f_s) begin
            state_nxt_s = ST_WAIT;
            lat_nxt_s   = LAT_INIT;
            if (win_d_s) begin
                owner_nxt_s = OWN_DATA;
                store_nxt_s = d_we;
            end else begin
                owner_nxt_s = OWN_FETCH;
                store_nxt_s = 1'b0;
            end
        end else if (state_r == ST_WAIT) begin
            if (complete_s) begin
                state_nxt_s = ST_IDLE;
                owner_nxt_s = OWN_NONE;
                lat_nxt_s   = {LAT_W{1'b0}};
                store_nxt_s = 1'b0;
            end else begin
                lat_nxt_s = lat_cnt_r - 3'd1;
            end
        end else begin
            state_nxt_s = ST_IDLE;
            owner_nxt_s = OWN_NONE;
        end
        // F waiting while D keeps winning is counted; any F grant or idle F clears it.
        if (win_f_s || !f_req) begin
            starve_nxt_s = {SC_W{1'b0}};
        end else if (win_d_s && (starve_cnt_r != SC_MAX)) begin
            starve_nxt_s = starve_cnt_r + {{(SC_W-1){1'b0}}, 1'b1};
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Outputs: grant and memory strobe track the winner; read data is routed to the owner only.
    always_comb begin
        f_gnt    = win_f_s;
        d_gnt    = win_d_s;
        m_en     = win_f_s | win_d_s;
        m_we     = 1'b0;
        m_addr   = {ADDR_W{1'b0}};
        m_wdata  = {WORD_W{1'b0}};
        f_rvalid = 1'b0;
        f_rdata  = {WORD_W{1'b0}};
        d_rvalid = 1'b0;
        d_rdata  = {WORD_W{1'b0}};
        if (win_d_s) begin
            m_addr = d_addr;
            if (d_we) begin
                m_we    = 1'b1;
                m_wdata = d_wdata;
            end else begin
                m_we    = 1'b0;
                m_wdata = {WORD_W{1'b0}};
            end
        end else if (win_f_s) begin
            m_addr = f_addr;
        end else begin
            m_addr = {ADDR_W{1'b0}};
        end
        if (complete_s && (owner_r == OWN_FETCH)) begin
            f_rvalid = 1'b1;
            f_rdata  = m_rdata;
        end else if (complete_s && (owner_r == OWN_DATA)) begin
            d_rvalid = 1'b1;
            if (store_r) begin
                d_rdata = {WORD_W{1'b0}};
            end else begin
                d_rdata = m_rdata;
            end
        end else begin
            f_rvalid = 1'b0;
            d_rvalid = 1'b0;
        end
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each
// with its own memory macro model, checked every cycle against a
// transaction-level reference (completion cycle number, owner, expected data),
// plus directed scenarios pinned with literal values.
module tb_mem_port_arbiter;

    localparam int SMAX = 3;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        f_req [2];
    logic [15:0] f_addr [2];
    logic        f_gnt [2];
    logic        f_rvalid [2];
    logic [15:0] f_rdata [2];
    logic        d_req [2];
    logic        d_we [2];
    logic [15:0] d_addr [2];
    logic [15:0] d_wdata [2];
    logic        d_gnt [2];
    logic        d_rvalid [2];
    logic [15:0] d_rdata [2];
    logic        m_en [2];
    logic        m_we [2];
    logic [15:0] m_addr [2];
    logic [15:0] m_wdata [2];
    logic [15:0] m_rdata [2];

    logic [15:0] mem [2][1024];
    logic [15:0] pipe [2][4];

    // reference model state
    logic [15:0] ref_mem [2][1024];
    bit          busy [2];
    int          done_cyc [2];
    int          own [2];
    logic [15:0] exp_data [2];
    int          starve [2];
    bit          m_wd [2];
    bit          m_wf [2];
    bit          m_comp [2];
    int          lat_of [2];
    int          cyc;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_W(16), .ADDR_W(16), .MEM_LAT(LAT0), .STARVE_MAX(SMAX)) dut0 (
        .clk(clk), .reset(reset), .halt(halt),
        .f_req(f_req[0]), .f_addr(f_addr[0]), .f_gnt(f_gnt[0]),
        .f_rvalid(f_rvalid[0]), .f_rdata(f_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
        .m_rdata(m_rdata[0])
    );

    mem_port_arbiter #(.WORD_W(16), .ADDR_W(16), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) dut1 (
        .clk(clk), .reset(reset), .halt(halt),
        .f_req(f_req[1]), .f_addr(f_addr[1]), .f_gnt(f_gnt[1]),
        .f_rvalid(f_rvalid[1]), .f_rdata(f_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
        .m_rdata(m_rdata[1])
    );

    // Memory macros: write on the strobe edge, read data emerges MEM_LAT cycles after m_en.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_en[k] && m_we[k]) mem[k][m_addr[k][9:0]] <= m_wdata[k];
            pipe[k][0] <= mem[k][m_addr[k][9:0]];
            for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
        end
    end
    assign m_rdata[0] = pipe[0][LAT0-1];
    assign m_rdata[1] = pipe[1][LAT1-1];

    function automatic logic [69:0] act_vec(int k);
        return {f_gnt[k], d_gnt[k], f_rvalid[k], d_rvalid[k], m_en[k], m_we[k],
                f_rdata[k], d_rdata[k], m_addr[k], m_wdata[k]};
    endfunction

    task automatic lit(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic preload(input int k, input int a, input logic [15:0] v);
        mem[k][a] = v;
        ref_mem[k][a] = v;
    endtask

    // Sample away from the active edge and compare each instance against the reference.
    task automatic sample();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bit comp;
            bit open;
            bit wd;
            bit wf;
            logic [15:0] fr_e, dr_e, fr_m, dr_m, ma_m, mw_m, ma_e;
            logic [69:0] ev, mv, av;
            comp = busy[k] && (cyc == done_cyc[k]);
            open = reset && !halt && (!busy[k] || comp);
            wd = open && d_req[k] && !(f_req[k] && (starve[k] == SMAX));
            wf = open && !wd && f_req[k];
            fr_e = (comp && own[k] == 1) ? exp_data[k] : 16'h0000;
            dr_e = (comp && own[k] == 2) ? exp_data[k] : 16'h0000;
            fr_m = (own[k] == 1 && !comp) ? 16'h0000 : 16'hFFFF;
            dr_m = (own[k] == 2 && !comp) ? 16'h0000 : 16'hFFFF;
            ma_e = wd ? d_addr[k] : f_addr[k];
            ma_m = (wd || wf) ? 16'hFFFF : 16'h0000;
            mw_m = (wd && d_we[k]) ? 16'hFFFF : 16'h0000;
            ev = {wf, wd, comp && (own[k] == 1), comp && (own[k] == 2), wd || wf, wd && d_we[k],
                  fr_e, dr_e, ma_e, d_wdata[k]};
            mv = {6'h3F, fr_m, dr_m, ma_m, mw_m};
            if (!reset) begin
                ev = 70'd0;
                mv = {70{1'b1}};
            end
            m_wd[k] = wd;
            m_wf[k] = wf;
            m_comp[k] = comp;
            av = act_vec(k);
            checks++;
            if ((av & mv) !== (ev & mv)) begin
                errors++;
                $display("FAIL model inst%0d cyc %0d got %0h want %0h mask %0h", k, cyc, av, ev, mv);
            end
        end
    endtask

    // Advance the reference over the active edge, then leave #1 for input changes.
    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                busy[k] = 1'b0;
                own[k] = 0;
                starve[k] = 0;
            end else begin
                if (m_wd[k] || m_wf[k]) begin
                    logic [15:0] a;
                    a = m_wd[k] ? d_addr[k] : f_addr[k];
                    if (m_wd[k] && d_we[k]) begin
                        ref_mem[k][a[9:0]] = d_wdata[k];
                        exp_data[k] = 16'h0000;
                    end else begin
                        exp_data[k] = ref_mem[k][a[9:0]];
                    end
                    busy[k] = 1'b1;
                    done_cyc[k] = cyc + lat_of[k];
                    own[k] = m_wd[k] ? 2 : 1;
                end else if (m_comp[k]) begin
                    busy[k] = 1'b0;
                    own[k] = 0;
                end
                if (m_wf[k] || !f_req[k]) starve[k] = 0;
                else if (m_wd[k] && starve[k] < SMAX) starve[k] = starve[k] + 1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < 2; k++) begin
            f_req[k] = 1'b0;
            d_req[k] = 1'b0;
        end
        halt = 1'b0;
        repeat (n) begin
            sample();
            advance();
        end
    endtask

    initial begin
        logic [7:0] fpat;
        checks = 0;
        errors = 0;
        cyc = 0;
        lat_of[0] = LAT0;
        lat_of[1] = LAT1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) begin
                mem[k][i] = 16'($urandom);
                ref_mem[k][i] = mem[k][i];
            end
            for (int i = 0; i < 4; i++) pipe[k][i] = 16'h0000;
            busy[k] = 1'b0; own[k] = 0; starve[k] = 0; done_cyc[k] = 0; exp_data[k] = 16'h0000;
            f_req[k] = 1'b0; f_addr[k] = 16'h0000;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 16'h0000; d_wdata[k] = 16'h0000;
            preload(k, 16'h0010, 16'h9005);
            preload(k, 16'h0020, 16'h5A5A);
            preload(k, 16'h0100, 16'h1234);
            preload(k, 16'h0040, 16'h7777);
        end
        halt = 1'b0;
        reset = 1'b0;
        f_req[0] = 1'b1;
        f_addr[0] = 16'h0010;

        // reset: request pending but nothing is granted
        repeat (2) begin
            sample();
            lit("rst_outputs0", act_vec(0), 70'd0);
            advance();
        end
        reset = 1'b1;

        // F read, MEM_LAT=1
        sample();
        lit("f_gnt_T", {f_gnt[0], m_en[0], m_addr[0]}, {1'b1, 1'b1, 16'h0010});
        advance();
        f_req[0] = 1'b0;
        sample();
        lit("f_rdata_T1", {f_rvalid[0], f_rdata[0]}, {1'b1, 16'h9005});
        advance();
        idle(2);

        // simultaneous F and D load: D wins first
        f_req[0] = 1'b1; f_addr[0] = 16'h0020;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0100;
        sample();
        lit("sim_first", {d_gnt[0], f_gnt[0]}, {1'b1, 1'b0});
        advance();
        d_req[0] = 1'b0;
        sample();
        lit("sim_second", {f_gnt[0], d_rvalid[0], d_rdata[0]}, {1'b1, 1'b1, 16'h1234});
        advance();
        f_req[0] = 1'b0;
        sample();
        lit("sim_fdata", {f_rvalid[0], f_rdata[0]}, {1'b1, 16'h5A5A});
        advance();
        idle(2);

        // starvation: F and D held, pattern DDDF DDDF
        f_req[0] = 1'b1; f_addr[0] = 16'h0010;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0100;
        fpat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sample();
            fpat[i] = f_gnt[0];
            lit("starve_onegnt", {f_gnt[0] ^ d_gnt[0]}, {1'b1});
            advance();
        end
        lit("starve_pattern", {fpat}, {8'h88});

        // store then load of the same word
        f_req[0] = 1'b0;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0040; d_wdata[0] = 16'hBEEF;
        sample();
        lit("store_issue", {d_gnt[0], m_we[0], m_wdata[0], m_addr[0]}, {1'b1, 1'b1, 16'hBEEF, 16'h0040});
        advance();
        d_we[0] = 1'b0;
        sample();
        lit("store_ack", {d_rvalid[0], d_rdata[0], d_gnt[0], m_we[0]}, {1'b1, 16'h0000, 1'b1, 1'b0});
        advance();
        d_req[0] = 1'b0;
        sample();
        lit("load_back", {d_rvalid[0], d_rdata[0]}, {1'b1, 16'hBEEF});
        advance();
        idle(2);

        // MEM_LAT=3 with halt raised the cycle after an F issue
        f_req[1] = 1'b1; f_addr[1] = 16'h0010;
        sample();
        lit("h_fgnt", {f_gnt[1]}, {1'b1});
        advance();
        f_req[1] = 1'b0; halt = 1'b1;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'h0100;
        for (int i = 1; i <= 4; i++) begin
            sample();
            lit("h_no_dgnt", {d_gnt[1], f_gnt[1]}, {1'b0, 1'b0});
            if (i == 3) lit("h_frv", {f_rvalid[1], f_rdata[1]}, {1'b1, 16'h9005});
            else lit("h_frv_quiet", {f_rvalid[1]}, {1'b0});
            advance();
        end
        halt = 1'b0;
        sample();
        lit("h_dgnt_release", {d_gnt[1]}, {1'b1});
        advance();
        d_req[1] = 1'b0;
        idle(4);

        // reset one cycle after a D grant, MEM_LAT=3
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'h0040;
        sample();
        lit("r_dgnt", {d_gnt[1]}, {1'b1});
        advance();
        d_req[1] = 1'b0;
        reset = 1'b0;
        f_req[1] = 1'b1; f_addr[1] = 16'h0020;
        repeat (2) begin
            sample();
            lit("r_zero", act_vec(1), 70'd0);
            advance();
        end
        reset = 1'b1;
        sample();
        lit("r_after", {d_rvalid[1], f_gnt[1]}, {1'b0, 1'b1});
        advance();
        f_req[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            lit("r_no_drv", {d_rvalid[1]}, {1'b0});
            advance();
        end
        idle(2);

        // randomized traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            sample();
            advance();
            for (int k = 0; k < 2; k++) begin
                if (!f_req[k] || m_wf[k]) begin
                    f_req[k] = ($urandom_range(0, 9) < 6);
                    f_addr[k] = 16'($urandom);
                end
                if (!d_req[k] || m_wd[k]) begin
                    d_req[k] = ($urandom_range(0, 9) < 6);
                    d_we[k] = ($urandom_range(0, 2) == 0);
                    d_addr[k] = 16'($urandom_range(0, 63));
                    d_wdata[k] = 16'($urandom);
                end
            end
            halt = ($urandom_range(0, 15) == 0);
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
